// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED bar sequencer: mode encoding,
// scan direction and the pattern each mode starts from.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        CHASE = 2'd1,
        ALT   = 2'd2,
        FILL  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [7:0] INIT_SCAN  = 8'h01;
    localparam logic [7:0] INIT_CHASE = 8'h01;
    localparam logic [7:0] INIT_ALT   = 8'hAA;
    localparam logic [7:0] INIT_FILL  = 8'h00;

    function automatic logic [7:0] init_pattern(input mode_t m);
        case (m)
            SCAN:    return INIT_SCAN;
            CHASE:   return INIT_CHASE;
            ALT:     return INIT_ALT;
            default: return INIT_FILL;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button to single-cycle press pulse: 2-flop synchronizer, stability
// counter, and a rising-edge pulse on the accepted (stable) level.
module button_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd32000
) (
    input  logic clk,
    input  logic reset_,
    input  logic btn,
    output logic press
);

    logic [1:0]  sync_q;
    logic        stable_q;
    logic [15:0] cnt_q;
    logic        press_q;
    logic        synced;
    logic        differs;
    logic        accept;

    assign synced  = sync_q[1];
    assign differs = synced != stable_q;
    assign accept  = differs && (cnt_q == DEBOUNCE_CYCLES - 16'd1);
    assign press   = press_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            // Pulse only when a new high level is accepted; releases are silent.
            press_q <= accept && synced;
            if (!differs) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable_q <= synced;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_controller.sv
// Top-level 8-LED bar sequencer: debounced mode/pause buttons, a programmable
// step tick and four display patterns.
module led_pattern_controller
    import led_ctrl_pkg::*;
#(
    parameter logic [21:0] TICK_PERIOD     = 22'd3993608,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd32000
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       btn_mode,
    input  logic       btn_pause,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       paused
);

    logic [1:0] btn_raw;
    logic [1:0] btn_press;
    logic       mode_press;
    logic       pause_press;

    assign btn_raw     = {btn_pause, btn_mode};
    assign mode_press  = btn_press[0];
    assign pause_press = btn_press[1];

    for (genvar g = 0; g < 2; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset_(reset_),
            .btn   (btn_raw[g]),
            .press (btn_press[g])
        );
    end

    mode_t       mode_q, mode_d;
    dir_t        dir_q, dir_d;
    logic [7:0]  led_q, led_d;
    logic [21:0] cnt_q, cnt_d;
    logic        paused_q, paused_d;
    logic        tick;

    assign tick = cnt_q == TICK_PERIOD;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mode_q   <= SCAN;
            dir_q    <= DIR_LEFT;
            led_q    <= INIT_SCAN;
            cnt_q    <= '0;
            paused_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            paused_q <= paused_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        led_d    = led_q;
        cnt_d    = cnt_q;
        paused_d = paused_q ^ pause_press;

        if (!paused_q) cnt_d = tick ? '0 : cnt_q + 22'd1;

        // A mode press restarts the pattern and the tick, overriding any step due now.
        if (mode_press) begin
            mode_d = mode_t'(mode_q + 2'd1);
            led_d  = init_pattern(mode_d);
            dir_d  = DIR_LEFT;
            cnt_d  = '0;
        end else if (tick && !paused_q) begin
            case (mode_q)
                SCAN: begin
                    if (dir_q == DIR_LEFT) begin
                        led_d = led_q << 1;
                        if (led_d == 8'h80) dir_d = DIR_RIGHT;
                    end else begin
                        led_d = led_q >> 1;
                        if (led_d == 8'h01) dir_d = DIR_LEFT;
                    end
                end
                CHASE:   led_d = {led_q[6:0], led_q[7]};
                ALT:     led_d = ~led_q;
                FILL:    led_d = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
                default: led_d = led_q;
            endcase
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with a 4-cycle tick and 4-sample debounce.
module tb_led_pattern_controller;

    logic       clk = 1'b0;
    logic       reset_;
    logic       btn_mode;
    logic       btn_pause;
    logic [7:0] led;
    logic [1:0] mode;
    logic       paused;

    int n_cmp = 0;
    int n_err = 0;

    led_pattern_controller #(
        .TICK_PERIOD    (22'd3),
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .btn_mode (btn_mode),
        .btn_pause(btn_pause),
        .led      (led),
        .mode     (mode),
        .paused   (paused)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bm;
        logic       bp;
        int         n;
        logic [7:0] led;
        logic [1:0] mode;
        logic       paused;
    } vec_t;

    vec_t vq[$];

    logic [7:0] scan_seq [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    logic [7:0] fill_seq [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                  8'hFF, 8'h00, 8'h01};

    task automatic add(input logic bm, input logic bp, input int n,
                       input logic [7:0] l, input logic [1:0] m, input logic p);
        vec_t v;
        v.bm = bm; v.bp = bp; v.n = n; v.led = l; v.mode = m; v.paused = p;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [7:0] l,
                           input logic [1:0] m, input logic p);
        chk({name, ".led"}, led, l);
        chk({name, ".mode"}, {6'b0, mode}, {6'b0, m});
        chk({name, ".paused"}, {7'b0, paused}, {7'b0, p});
    endtask

    initial begin
        int bad;
        reset_ = 1'b0; btn_mode = 1'b0; btn_pause = 1'b0;
        cyc(2);
        chk_all("reset", 8'h01, 2'd0, 1'b0);
        reset_ = 1'b1;

        // Scanner over two full periods
        for (int k = 1; k <= 28; k++) add(0, 0, 4, scan_seq[k % 14], 2'd0, 0);
        // Held mode press: one press only, then chase
        add(1, 0, 6, 8'h02, 2'd0, 0);
        add(1, 0, 1, 8'h01, 2'd1, 0);
        add(1, 0, 4, 8'h02, 2'd1, 0);
        add(1, 0, 4, 8'h04, 2'd1, 0);
        add(1, 0, 4, 8'h08, 2'd1, 0);
        add(1, 0, 1, 8'h08, 2'd1, 0);
        add(0, 0, 3, 8'h10, 2'd1, 0);
        add(0, 0, 4, 8'h20, 2'd1, 0);
        add(0, 0, 4, 8'h40, 2'd1, 0);
        add(0, 0, 4, 8'h80, 2'd1, 0);
        add(0, 0, 4, 8'h01, 2'd1, 0);
        // Glitchy mode button: rejected
        add(1, 0, 2, 8'h01, 2'd1, 0);
        add(0, 0, 2, 8'h02, 2'd1, 0);
        add(1, 0, 2, 8'h02, 2'd1, 0);
        add(0, 0, 2, 8'h04, 2'd1, 0);
        add(0, 0, 4, 8'h08, 2'd1, 0);
        // To ALT
        add(1, 0, 6, 8'h10, 2'd1, 0);
        add(1, 0, 1, 8'hAA, 2'd2, 0);
        add(0, 0, 4, 8'h55, 2'd2, 0);
        add(0, 0, 4, 8'hAA, 2'd2, 0);
        // To FILL
        add(1, 0, 4, 8'h55, 2'd2, 0);
        add(1, 0, 2, 8'h55, 2'd2, 0);
        add(1, 0, 1, 8'h00, 2'd3, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 4, fill_seq[k], 2'd3, 0);
        // Wrap back to SCAN
        add(1, 0, 4, 8'h03, 2'd3, 0);
        add(1, 0, 2, 8'h03, 2'd3, 0);
        add(1, 0, 1, 8'h01, 2'd0, 0);
        add(0, 0, 4, 8'h02, 2'd0, 0);

        foreach (vq[i]) begin
            btn_mode = vq[i].bm;
            btn_pause = vq[i].bp;
            cyc(vq[i].n);
            chk_all($sformatf("vec%0d", i), vq[i].led, vq[i].mode, vq[i].paused);
        end

        // Pause lands while led=08 with one cycle of the tick already counted
        cyc(2);
        btn_pause = 1'b1;
        cyc(2); chk("pause.pre04", led, 8'h04);
        cyc(4); chk_all("pause.pre08", 8'h08, 2'd0, 1'b0);
        cyc(1); chk_all("pause.on", 8'h08, 2'd0, 1'b1);
        btn_pause = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (led !== 8'h08 || paused !== 1'b1) bad++;
        end
        chk("pause.hold_bad_cycles", bad[7:0], 8'h00);
        btn_pause = 1'b1;
        cyc(7); chk_all("pause.off", 8'h08, 2'd0, 1'b0);
        btn_pause = 1'b0;
        cyc(2); chk("resume.not_yet", led, 8'h08);
        cyc(1); chk("resume.step", led, 8'h10);
        cyc(4); chk("resume.next", led, 8'h20);

        // Mode press coinciding with a tick
        cyc(1);
        btn_mode = 1'b1;
        cyc(3); chk("coinc.pre", led, 8'h40);
        cyc(4); chk_all("coinc.press", 8'h01, 2'd1, 1'b0);
        btn_mode = 1'b0;
        cyc(3); chk("coinc.hold", led, 8'h01);
        cyc(1); chk("coinc.step", led, 8'h02);

        // Asynchronous reset mid-cycle
        #3 reset_ = 1'b0;
        #1 chk_all("async_reset", 8'h01, 2'd0, 1'b0);
        cyc(2);
        reset_ = 1'b1;
        cyc(4); chk_all("post_reset.step", 8'h02, 2'd0, 1'b0);
        cyc(8); chk_all("post_reset.later", 8'h08, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
